// File: rtl/rol_iter_pkg.sv
// Shared logic-unit package: state encodings and default operand/amount widths
// used by both the rotate-left and rotate-right units.
package rol_iter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SHW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rol_step.sv
// Single-position rotate-left of a WIDTH-bit word; also reports the bit that
// wrapped from the MSB into the LSB.
module rol_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             bit_o
);

  assign data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
  assign bit_o  = data_i[WIDTH-1];

endmodule

// File: rtl/rol_iter.sv
// Iterative rotate-left unit: captures an operand and amount on start, rotates
// one position per clock, pulses done and holds the result until the next start.
module rol_iter
  import rol_iter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Aout,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aout_q, aout_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      shamtWide;
  logic [CW-1:0]    amtMod;
  logic [WIDTH-1:0] stepData;
  logic             stepBit;

  // Reducing the amount at capture keeps cnt within log2(WIDTH) bits.
  assign shamtWide = 32'(shamt);
  assign amtMod    = CW'(shamtWide % 32'(WIDTH));

  rol_step #(.WIDTH(WIDTH)) u_step (
    .data_i (aout_q),
    .data_o (stepData),
    .bit_o  (stepBit)
  );

  always_comb begin
    state_d = state_q;
    aout_d  = aout_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          aout_d  = Ain;
          cout_d  = 1'b0;
          cnt_d   = amtMod;
          state_d = (amtMod == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        aout_d  = stepData;
        cout_d  = stepBit;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      aout_q  <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aout_q  <= aout_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Aout = aout_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_rol_iter.sv
// Self-checking bench for rol_iter: a transaction-level reference model checked
// every cycle, plus directed cases with hand-computed expectations.
module tb_rol_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] Ain;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] Aout;
  logic        cout;

  int vectors = 0;
  int errors  = 0;
  bit checkEn = 0;

  rol_iter #(.WIDTH(16), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Ain   (Ain),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .Aout  (Aout),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rolRef(input logic [15:0] a, input int k);
    int kk;
    kk = k % 16;
    if (kk == 0) return a;
    return (a << kk) | (a >> (16 - kk));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: an accepted operation is just (operand, amount, rotations so far);
  // the visible word is the operand rotated by the rotations completed.
  logic [15:0] opA = '0;
  int          opK = 0;
  int          opN = 0;
  logic [15:0] mA  = '0;
  bit          mC  = 0;
  bit          mBusy = 0;
  bit          mDone = 0;

  always @(posedge clk) begin
    if (rst) begin
      mA = '0; mC = 0; mBusy = 0; mDone = 0; opN = 0;
    end else if (start && !mBusy) begin
      opA = Ain; opK = int'(shamt) % 16; opN = 0;
      mA = Ain; mC = 0;
      mBusy = (opK != 0); mDone = (opK == 0);
    end else if (mBusy) begin
      opN++;
      mA = rolRef(opA, opN);
      mC = mA[0];
      mBusy = (opN < opK); mDone = (opN == opK);
    end else begin
      mDone = 0;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_busy", 32'(busy), 32'(mBusy));
      checkOutput("cyc_done", 32'(done), 32'(mDone));
      checkOutput("cyc_aout", 32'(Aout), 32'(mA));
      checkOutput("cyc_cout", 32'(cout), 32'(mC));
    end
  end

  // Called just after the capture edge; returns after the edge that raised done.
  task automatic waitDone(output int busyCnt, output int lat, input bit noise);
    int e;
    e = 1; busyCnt = 0; lat = -1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = e;
        break;
      end
      if (busy) begin
        busyCnt++;
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          Ain   = 16'($urandom);
          shamt = 5'($urandom);
        end
      end
      @(posedge clk); #1; e++;
    end
    start = 1'b0;
    if (lat < 0) checkOutput("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [4:0] sh, input bit noise,
                               output int busyCnt, output int lat);
    Ain = a; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    waitDone(busyCnt, lat, noise);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [4:0]  sh;
    logic [15:0] expA;
    logic        expC;
    int          expBusy;
  } vec_t;

  vec_t table_q[$];

  initial begin
    int bc, lat, gap, seenDone;
    logic [15:0] ra;
    logic [4:0]  rs;

    rst = 1'b1; start = 1'b0; Ain = '0; shamt = '0;
    @(posedge clk); #1;
    checkEn = 1;
    @(posedge clk); #1;
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_aout", 32'(Aout), 32'(0));
    checkOutput("rst_cout", 32'(cout), 32'(0));
    rst = 1'b0;

    // Hand-computed cases: basic, multi-step, zero and modular amounts.
    table_q.push_back('{16'h8001, 5'd1,  16'h0003, 1'b1, 1});
    table_q.push_back('{16'h1234, 5'd4,  16'h2341, 1'b1, 4});
    table_q.push_back('{16'h1234, 5'd0,  16'h1234, 1'b0, 0});
    table_q.push_back('{16'h1234, 5'd16, 16'h1234, 1'b0, 0});
    table_q.push_back('{16'h1234, 5'd31, 16'h091A, 1'b0, 15});
    foreach (table_q[i]) begin
      applyStimulus(table_q[i].a, table_q[i].sh, 1'b0, bc, lat);
      checkOutput($sformatf("dir%0d_busy", i), 32'(bc), 32'(table_q[i].expBusy));
      checkOutput($sformatf("dir%0d_lat", i), 32'(lat), 32'(table_q[i].expBusy + 1));
      checkOutput($sformatf("dir%0d_aout", i), 32'(Aout), 32'(table_q[i].expA));
      checkOutput($sformatf("dir%0d_cout", i), 32'(cout), 32'(table_q[i].expC));
      if (i == 1) begin
        repeat (10) begin
          @(posedge clk); #1;
          checkOutput("hold_aout", 32'(Aout), 32'h2341);
          checkOutput("hold_done", 32'(done), 32'(0));
        end
      end
      @(posedge clk); #1;
    end

    // Start pulsed mid-run is ignored; start in the DONE cycle is accepted.
    Ain = 16'h00FF; shamt = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bc = 0; lat = -1;
    for (int e = 1; e < 40; e++) begin
      if (done) begin
        lat = e;
        break;
      end
      if (busy) bc++;
      if (e == 3) begin
        start = 1'b1; Ain = 16'hFFFF; shamt = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checkOutput("ign_busy", 32'(bc), 32'(8));
    checkOutput("ign_lat", 32'(lat), 32'(9));
    checkOutput("ign_aout", 32'(Aout), 32'hFF00);
    checkOutput("ign_cout", 32'(cout), 32'(0));
    applyStimulus(16'h0001, 5'd2, 1'b0, bc, lat);
    checkOutput("b2b_busy", 32'(bc), 32'(2));
    checkOutput("b2b_lat", 32'(lat), 32'(3));
    checkOutput("b2b_aout", 32'(Aout), 32'h0004);
    @(posedge clk); #1;

    // Reset during the fifth RUN cycle aborts without a done pulse.
    Ain = 16'hABCD; shamt = 5'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bc = 0;
    for (int i = 0; i < 40 && bc < 5; i++) begin
      if (busy) bc++;
      if (bc < 5) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    checkOutput("abort_aout", 32'(Aout), 32'(0));
    checkOutput("abort_cout", 32'(cout), 32'(0));
    seenDone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seenDone++;
    end
    checkOutput("abort_nodone", 32'(seenDone), 32'(0));
    applyStimulus(16'h0F00, 5'd4, 1'b0, bc, lat);
    checkOutput("fresh_lat", 32'(lat), 32'(5));
    checkOutput("fresh_aout", 32'(Aout), 32'hF000);
    checkOutput("fresh_cout", 32'(cout), 32'(0));

    // Random regression with gaps and stray starts while busy.
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      ra = 16'($urandom);
      rs = 5'($urandom);
      applyStimulus(ra, rs, (n % 3) == 0, bc, lat);
      checkOutput("rnd_lat", 32'(lat), 32'(int'(rs) % 16 + 1));
      checkOutput("rnd_aout", 32'(Aout), 32'(rolRef(ra, int'(rs))));
    end

    @(posedge clk); #1;
    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
